// File: rtl/onchip_mem_pkg.sv
// Shared types and helpers for the dual-port on-chip memory.
package onchip_mem_pkg;

  // Sequencer states: held in RESET, zero-fill in CLEAR, serve traffic in READY.
  typedef enum logic [1:0] {
    RESET = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } mem_state_t;

  // Supported read latencies (accept edge to readdatavalid).
  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  // Ceiling log2, used to size the physical word index.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/onchip_mem_bank.sv
// True dual-port byte-enabled RAM; reads return the pre-write contents.
module onchip_mem_bank
  import onchip_mem_pkg::*;
#(
  parameter int DW           = 32,
  parameter int BW           = 8,
  parameter int NB           = 4,
  parameter int DEPTH        = 16,
  parameter int IW           = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic [1:0]          we,
  input  logic [1:0][IW-1:0]  addr,
  input  logic [1:0][NB-1:0]  be,
  input  logic [1:0][DW-1:0]  wdata,
  output logic [1:0][DW-1:0]  q
);

  logic [DW-1:0]         mem [DEPTH];
  logic [1:0][DW-1:0]    q_raw;

  // Both ports read and write every cycle; NBA ordering gives old-data reads.
  // Port 0 is written last so it wins any lane overlap the top did not mask.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) q_raw[p] <= mem[addr[p]];
    for (int p = 1; p >= 0; p--) begin
      if (we[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be[p][b]) mem[addr[p]][b*BW +: BW] <= wdata[p][b*BW +: BW];
        end
      end
    end
  end

  if (READ_LATENCY == RL_MAX) begin : g_oreg
    logic [1:0][DW-1:0] q_reg;
    // Extra output stage for the two-cycle latency variant.
    always_ff @(posedge clk) q_reg <= q_raw;
    assign q = q_reg;
  end else begin : g_noreg
    assign q = q_raw;
  end

endmodule

// File: rtl/onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip RAM: fill sequencer, range checks,
// cross-port write masking and readdatavalid pipelines around the bank.
module onchip_memory_dp
  import onchip_mem_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int BYTE_WIDTH     = 8,
  parameter  int DEPTH          = 25000,
  parameter  int ADDR_WIDTH     = 15,
  parameter  int READ_LATENCY   = 1,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int NUM_BYTES      = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [NUM_BYTES-1:0]  s1_byteenable,
  input  logic [DATA_WIDTH-1:0] s1_writedata,
  output logic [DATA_WIDTH-1:0] s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0] s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [NUM_BYTES-1:0]  s2_byteenable,
  input  logic [DATA_WIDTH-1:0] s2_writedata,
  output logic [DATA_WIDTH-1:0] s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest,
  output logic                  busy
);

  localparam int IW     = clog2(DEPTH);
  localparam int STAGES = READ_LATENCY;

  if (READ_LATENCY != RL_MIN && READ_LATENCY != RL_MAX) begin : g_bad_rl
    $error("onchip_memory_dp: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $error("onchip_memory_dp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  mem_state_t    state_q, state_d;
  logic [IW-1:0] fill_addr;
  logic          fill, wait_w;

  // Sequencer state and fill pointer; any reset restarts the fill at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET;
      fill_addr <= '0;
    end else begin
      state_q <= state_d;
      if (fill) fill_addr <= fill_addr + 1'b1;
    end
  end

  // Next state: one pass over the array, then READY forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:   state_d = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      CLEAR:   if (fill_addr == IW'(DEPTH - 1)) state_d = READY;
      READY:   state_d = READY;
      default: state_d = RESET;
    endcase
  end

  assign fill   = (state_q == CLEAR);
  assign wait_w = (state_q != READY);
  assign busy   = fill | ((state_q == RESET) && (CLEAR_ON_RESET != 0));

  // Index 0 is s1, index 1 is s2.
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0]                 cs, rd, wr;
  logic [1:0][NUM_BYTES-1:0]  be;
  logic [1:0][DATA_WIDTH-1:0] wdata;

  assign addr  = {s2_address, s1_address};
  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};

  logic [1:0]                in_rng, rd_acc, wr_en;
  logic [1:0][NUM_BYTES-1:0] be_eff;

  // Accept decode; read+write on one port keeps the write and drops the read.
  // On a same-address double write, s2 keeps only lanes s1 does not touch.
  always_comb begin
    be_eff = be;
    for (int p = 0; p < 2; p++) begin
      in_rng[p] = 32'(addr[p]) < 32'(DEPTH);
      rd_acc[p] = cs[p] & rd[p] & ~wr[p] & ~wait_w;
      wr_en[p]  = cs[p] & wr[p] & ~wait_w & in_rng[p];
    end
    if (wr_en[0] && wr_en[1] && addr[0] == addr[1]) be_eff[1] = be[1] & ~be[0];
  end

  logic [1:0]                 bank_we;
  logic [1:0][IW-1:0]         bank_addr;
  logic [1:0][NUM_BYTES-1:0]  bank_be;
  logic [1:0][DATA_WIDTH-1:0] bank_wdata, bank_q;

  // The fill borrows port 0 while both ports are stalled.
  always_comb begin
    bank_we    = wr_en;
    bank_be    = be_eff;
    bank_wdata = wdata;
    for (int p = 0; p < 2; p++) bank_addr[p] = addr[p][IW-1:0];
    if (fill) begin
      bank_we[0]    = 1'b1;
      bank_addr[0]  = fill_addr;
      bank_be[0]    = '1;
      bank_wdata[0] = '0;
    end
  end

  onchip_mem_bank #(
    .DW(DATA_WIDTH), .BW(BYTE_WIDTH), .NB(NUM_BYTES),
    .DEPTH(DEPTH), .IW(IW), .READ_LATENCY(READ_LATENCY)
  ) u_bank (
    .clk(clk), .we(bank_we), .addr(bank_addr), .be(bank_be),
    .wdata(bank_wdata), .q(bank_q)
  );

  logic [STAGES:0]     vld_pipe [2];
  logic [STAGES-1:0]   oor_pipe [2];
  logic [DATA_WIDTH-1:0] rdata_q [2];

  // Valid/out-of-range tracking; readdata loads only for a returning read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        vld_pipe[p] <= '0;
        oor_pipe[p] <= '0;
        rdata_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_pipe[p]    <= {vld_pipe[p][STAGES-1:0], rd_acc[p]};
        oor_pipe[p][0] <= ~in_rng[p];
        for (int i = 1; i < STAGES; i++) oor_pipe[p][i] <= oor_pipe[p][i-1];
        if (vld_pipe[p][STAGES-1])
          rdata_q[p] <= oor_pipe[p][STAGES-1] ? '0 : bank_q[p];
      end
    end
  end

  assign s1_readdata      = rdata_q[0];
  assign s2_readdata      = rdata_q[1];
  assign s1_readdatavalid = vld_pipe[0][STAGES];
  assign s2_readdatavalid = vld_pipe[1][STAGES];
  assign s1_waitrequest   = wait_w;
  assign s2_waitrequest   = wait_w;

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed bench: latency-1 and latency-2 instances (DEPTH 16) share stimulus.
module tb_onchip_memory_dp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  addr [2];
  logic        cs [2], rd [2], wr [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];
  logic [31:0] rdata [2][2];
  logic        rdv [2][2], wreq [2][2];
  logic        busy [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    onchip_memory_dp #(
      .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(5),
      .READ_LATENCY(d + 1), .CLEAR_ON_RESET(1)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]),
      .s1_write(wr[0]), .s1_byteenable(be[0]), .s1_writedata(wd[0]),
      .s1_readdata(rdata[d][0]), .s1_readdatavalid(rdv[d][0]),
      .s1_waitrequest(wreq[d][0]),
      .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]),
      .s2_write(wr[1]), .s2_byteenable(be[1]), .s2_writedata(wd[1]),
      .s2_readdata(rdata[d][1]), .s2_readdatavalid(rdv[d][1]),
      .s2_waitrequest(wreq[d][1]),
      .busy(busy[d])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 0; rd[p] = 0; wr[p] = 0; be[p] = 4'h0; wd[p] = 32'h0; addr[p] = 5'd0;
    end
  endtask

  task automatic rd_drive(input int p, input logic [4:0] a);
    cs[p] = 1; rd[p] = 1; wr[p] = 0; addr[p] = a;
  endtask

  task automatic wr_drive(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    cs[p] = 1; rd[p] = 0; wr[p] = 1; addr[p] = a; wd[p] = d; be[p] = b;
  endtask

  // Called right after the accept edge: L1 returns next edge, L2 one later.
  task automatic rd_expect(input int p, input logic [31:0] exp, input string tag);
    tick();
    chk({tag, " l1 vld"}, 32'(rdv[0][p]), 32'd1);
    chk({tag, " l1 data"}, rdata[0][p], exp);
    chk({tag, " l2 early"}, 32'(rdv[1][p]), 32'd0);
    tick();
    chk({tag, " l1 pulse"}, 32'(rdv[0][p]), 32'd0);
    chk({tag, " l1 hold"}, rdata[0][p], exp);
    chk({tag, " l2 vld"}, 32'(rdv[1][p]), 32'd1);
    chk({tag, " l2 data"}, rdata[1][p], exp);
  endtask

  task automatic read_chk(input int p, input logic [4:0] a, input logic [31:0] exp, input string tag);
    rd_drive(p, a);
    tick();
    idle();
    rd_expect(p, exp, tag);
  endtask

  task automatic wr_do(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_drive(p, a, d, b);
    tick();
    idle();
  endtask

  // Counts edges from reset release until waitrequest drops (bounded).
  task automatic fill_wait(input string tag);
    int cnt;
    cnt = 0;
    while (wreq[0][0] === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
      if (cnt == 10) chk({tag, " busy mid"}, 32'(busy[0]), 32'd1);
    end
    chk({tag, " fill len"}, cnt, 32'd17);
    chk({tag, " l2 wreq"}, 32'(wreq[1][1]), 32'd0);
    chk({tag, " busy done"}, 32'(busy[0] | busy[1]), 32'd0);
  endtask

  initial begin
    reset_n = 0;
    idle();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst rdata d%0d", d), rdata[d][0] | rdata[d][1], 32'h0);
      chk($sformatf("rst vld d%0d", d), 32'(rdv[d][0] | rdv[d][1]), 32'd0);
      chk($sformatf("rst wreq d%0d", d), 32'(wreq[d][0] & wreq[d][1]), 32'd1);
      chk($sformatf("rst busy d%0d", d), 32'(busy[d]), 32'd1);
    end
    reset_n = 1;
    fill_wait("fill1");

    read_chk(0, 5'd5, 32'h0, "rd5");
    read_chk(1, 5'd20, 32'h0, "oor rd20");

    wr_do(0, 5'd2, 32'hAABBCCDD, 4'b0101);
    read_chk(0, 5'd2, 32'h00BB00DD, "lane wr");
    read_chk(0, 5'd20, 32'h0, "oor after data");

    wr_do(0, 5'd16, 32'hFFFFFFFF, 4'hF);
    read_chk(0, 5'd2, 32'h00BB00DD, "pre oor chk");
    read_chk(0, 5'd0, 32'h0, "oor wr ignored");

    wr_do(0, 5'd2, 32'hFFFFFFFF, 4'h0);
    read_chk(1, 5'd2, 32'h00BB00DD, "be0 noop");

    wr_drive(0, 5'd3, 32'h11111111, 4'b0011);
    wr_drive(1, 5'd3, 32'h22222222, 4'b1111);
    tick();
    idle();
    read_chk(1, 5'd3, 32'h22221111, "wr collide");

    wr_do(0, 5'd7, 32'h5, 4'hF);
    rd_drive(1, 5'd7);
    wr_drive(0, 5'd7, 32'h9, 4'hF);
    tick();
    idle();
    rd_expect(1, 32'h5, "xrdw old");
    read_chk(1, 5'd7, 32'h9, "xrdw new");

    cs[0] = 1; rd[0] = 1; wr[0] = 1; addr[0] = 5'd8; wd[0] = 32'h33; be[0] = 4'hF;
    tick();
    idle();
    tick();
    chk("rw drop l1", 32'(rdv[0][0]), 32'd0);
    tick();
    chk("rw drop l2", 32'(rdv[1][0]), 32'd0);
    read_chk(0, 5'd8, 32'h33, "rw wrote");

    for (int i = 0; i < 8; i++) wr_do(0, 5'(8 + i), 32'h100 + 32'(i), 4'hF);
    for (int j = 0; j < 10; j++) begin
      if (j < 8) rd_drive(1, 5'(8 + j));
      else idle();
      tick();
      chk($sformatf("strm l1 vld %0d", j), 32'(rdv[0][1]), 32'((j >= 1) && (j <= 8)));
      chk($sformatf("strm l2 vld %0d", j), 32'(rdv[1][1]), 32'((j >= 2) && (j <= 9)));
      if (j >= 1 && j <= 8) chk($sformatf("strm l1 d %0d", j), rdata[0][1], 32'h100 + 32'(j - 1));
      if (j >= 2) chk($sformatf("strm l2 d %0d", j), rdata[1][1], 32'h100 + 32'(j - 2));
    end
    idle();

    rd_drive(0, 5'd9);
    tick();
    idle();
    reset_n = 0;
    tick();
    chk("rst inflight l1", 32'(rdv[0][0]), 32'd0);
    chk("rst rdata l1", rdata[0][0], 32'h0);
    tick();
    chk("rst inflight l2", 32'(rdv[1][0]), 32'd0);
    chk("rst rdata l2", rdata[1][0], 32'h0);

    reset_n = 1;
    repeat (10) tick();
    reset_n = 0;
    #1;
    chk("midfill wreq", 32'(wreq[0][0] & wreq[1][1]), 32'd1);
    chk("midfill busy", 32'(busy[0] & busy[1]), 32'd1);
    tick();
    tick();
    reset_n = 1;
    fill_wait("fill2");
    for (int a = 0; a < 16; a++) read_chk(1, 5'(a), 32'h0, $sformatf("refill a%0d", a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
